fp_add_round_pack: RTL and testbench
====================================

// Module: fp_add_round_pack
// PURPOSE
//  Final stage of the dual-path FP adder, directly downstream of the close and far paths.
//  Selects the active path result, rounds to nearest-even and detects exponent overflow/underflow.
//  Packs an IEEE-754 word through a 2-stage valid/ready pipeline.
//  Path results arrive normalized (hidden bit at MSB) with G/R/S bits and a widened signed exponent.
// PARAMETERS
//  SIZE_MANTISSA  24   mantissa width incl. hidden bit (1.M)
//  SIZE_EXPONENT  8    packed exponent width; bias = 2^(SIZE_EXPONENT-1)-1
//  SIZE_WORD      32   packed width = 1 + SIZE_EXPONENT + SIZE_MANTISSA - 1 (derived, do not override)
// PORTS
//  clk          in   1                  rising-edge clock
//  rst          in   1                  synchronous reset, active-high
//  in_valid     in   1                  input beat valid
//  in_ready     out  1                  stage can accept input
//  path_close   in   1                  1 = take close_*, 0 = take far_*
//  sign         in   1                  result sign
//  close_m      in   SIZE_MANTISSA      close-path normalized mantissa
//  close_e      in   SIZE_EXPONENT+2    close-path biased exponent, two's complement
//  close_grs    in   3                  close-path guard/round/sticky
//  far_m        in   SIZE_MANTISSA      far-path normalized mantissa
//  far_e        in   SIZE_EXPONENT+2    far-path biased exponent, two's complement
//  far_grs      in   3                  far-path guard/round/sticky
//  out_valid    out  1                  result valid
//  out_ready    in   1                  consumer accepts result
//  result       out  SIZE_WORD          packed {sign, exp, frac}
//  ovf_flag     out  1                  (FP_ADD_STATUS_EN only) result overflowed to infinity
//  unf_flag     out  1                  (FP_ADD_STATUS_EN only) result flushed to zero
//  inx_flag     out  1                  (FP_ADD_STATUS_EN only) grs != 0 or overflow
// BEHAVIOUR
//  - Reset: s1_valid = s2_valid = 0, out_valid = 0, result = 0, all flags = 0. Takes effect mid-stall; in-flight data is dropped.
//  - Handshake: adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1.
//    - Input transfer on in_valid & in_ready.
//    - S1 loads on transfer; S2 loads s1 contents when adv2.
//  - Stall: while out_valid & !out_ready, result and flags hold stable.
//  - Latency 2 cycles with out_ready = 1; throughput 1 beat/cycle. Beats leave in order; none lost or duplicated.
//  - S1 (select): register sign, and m/e/grs from the path picked by path_close.
//    - zero = (m == 0) is also registered.
//  - S2 (round+pack):
//    - inc = g & (r | s | m[0]).
//    - m_r = m + inc, computed SIZE_MANTISSA+1 bits wide.
//    - If m_r carries out: m_r >>= 1 and e += 1.
//    - Overflow: e >= 2^SIZE_EXPONENT-1 -> {sign, all-ones, 0} (infinity).
//    - Underflow: zero | e <= 0 (signed) -> {sign, 0, 0} (subnormals flushed).
//    - Otherwise: {sign, e[SIZE_EXPONENT-1:0], m_r[SIZE_MANTISSA-2:0]}.
//  - All exponent arithmetic is signed SIZE_EXPONENT+2 bits; no wrap is permitted.
//  - Simultaneous in_valid & out_ready with both stages full: shift through in one cycle.
// CONFIGURATION
//  - FP_ADD_STATUS_EN defined:
//    - ovf_flag, unf_flag and inx_flag exist.
//    - They are registered alongside result and share its valid and stall behaviour.
//  - FP_ADD_STATUS_EN undefined: those ports and their logic are absent; result is unchanged.
// TESTING
//  1. close, m=0xC00000, e=127, grs=000, sign=0, out_ready=1 -> result 0x3FC00000 exactly 2 cycles later.
//  2. far, m=0xFFFFFF, e=127, grs=100 -> round up and carry out -> 0x40000000, inx=1.
//  3. far, m=0x800000, e=127, grs=100 (tie, lsb even) -> 0x3F800000, inx=1.
//  4. far, m=0xFFFFFF, e=254, grs=110 -> 0x7F800000, ovf=1, inx=1.
//     Also close, m=0x800000, e=0, sign=1 -> 0x80000000, unf=1.
//  5. Backpressure: out_ready=0 and send 3 beats.
//     - Expect in_ready=0 after 2 accepted, result stable while stalled.
//     - Raise out_ready: all 3 results appear in order.
//  6. Assert rst during a stall -> next cycle out_valid=0, in_ready=1, result=0; no stale beat emerges afterwards.

Source files
------------

// File: rtl/fp_add_round_pack.sv
// Final stage of the dual-path FP adder: path select, round-to-nearest-even, pack, 2-stage pipe.
// Optional status flags (ovf/unf/inx) are built when FP_ADD_STATUS_EN is defined.
module fp_add_round_pack #(
  parameter int SIZE_MANTISSA = 24,
  parameter int SIZE_EXPONENT = 8,
  localparam int SIZE_WORD = 1 + SIZE_EXPONENT + SIZE_MANTISSA - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       path_close,
  input  logic                       sign,
  input  logic [SIZE_MANTISSA-1:0]   close_m,
  input  logic [SIZE_EXPONENT+1:0]   close_e,
  input  logic [2:0]                 close_grs,
  input  logic [SIZE_MANTISSA-1:0]   far_m,
  input  logic [SIZE_EXPONENT+1:0]   far_e,
  input  logic [2:0]                 far_grs,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE_WORD-1:0]       result
`ifdef FP_ADD_STATUS_EN
  ,
  output logic                       ovf_flag,
  output logic                       unf_flag,
  output logic                       inx_flag
`endif
);

  localparam int EW = SIZE_EXPONENT + 2;
  // One spare bit on top of the input exponent so the carry increment can never wrap.
  localparam logic signed [EW:0] E_MAX  = (EW+1)'((1 << SIZE_EXPONENT) - 1);
  localparam logic signed [EW:0] E_ZERO = '0;
  localparam logic signed [EW:0] E_ONE  = (EW+1)'(1);

  // Valid/ready: a beat moves across a boundary on the edge where the upstream valid and the
  // downstream ready are both high; a stage may load when it is empty or is itself being drained.
  logic adv1, adv2;
  logic s1_valid, s2_valid;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  logic                      s1_sign;
  logic [SIZE_MANTISSA-1:0]  s1_m;
  logic [EW-1:0]             s1_e;
  logic [2:0]                s1_grs;
  logic                      s1_zero;

  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_sign <= sign;
      if (path_close) begin
        s1_m    <= close_m;
        s1_e    <= close_e;
        s1_grs  <= close_grs;
        s1_zero <= (close_m == '0);
      end else begin
        s1_m    <= far_m;
        s1_e    <= far_e;
        s1_grs  <= far_grs;
        s1_zero <= (far_m == '0);
      end
    end
  end

  logic                      inc;
  logic [SIZE_MANTISSA:0]    m_sum;
  logic [SIZE_MANTISSA-2:0]  frac;
  logic signed [EW:0]        e_adj;
  logic                      ovf;
  logic                      unf;
  logic [SIZE_WORD-1:0]      packed_word;

  always_comb begin
    inc   = s1_grs[2] & (s1_grs[1] | s1_grs[0] | s1_m[0]);
    m_sum = {1'b0, s1_m} + {{SIZE_MANTISSA{1'b0}}, inc};
    e_adj = {s1_e[EW-1], s1_e};
    frac  = m_sum[SIZE_MANTISSA-2:0];
    if (m_sum[SIZE_MANTISSA]) begin
      frac  = m_sum[SIZE_MANTISSA-1:1];
      e_adj = e_adj + E_ONE;
    end
    ovf = (e_adj >= E_MAX);
    unf = !ovf && (s1_zero || (e_adj <= E_ZERO));
    if (ovf) begin
      packed_word = {s1_sign, {SIZE_EXPONENT{1'b1}}, {(SIZE_MANTISSA-1){1'b0}}};
    end else if (unf) begin
      packed_word = {s1_sign, {(SIZE_WORD-1){1'b0}}};
    end else begin
      packed_word = {s1_sign, e_adj[SIZE_EXPONENT-1:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      result   <= '0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) result <= packed_word;
      end
    end
  end

`ifdef FP_ADD_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
      inx_flag <= 1'b0;
    end else if (adv2 && s1_valid) begin
      ovf_flag <= ovf;
      unf_flag <= unf;
      inx_flag <= (s1_grs != 3'b000) || ovf;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_round_pack.sv
// Bench for fp_add_round_pack: directed cases, backpressure, reset-in-stall, then random beats
// scored against an arithmetic reference model. Flags are checked when FP_ADD_STATUS_EN is defined.
module tb_fp_add_round_pack;

  localparam int W = 35;
`ifdef FP_ADD_STATUS_EN
  localparam logic [W-1:0] CMP_MASK = {W{1'b1}};
`else
  localparam logic [W-1:0] CMP_MASK = {{32{1'b1}}, 3'b000};
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        path_close;
  logic        sign;
  logic [23:0] close_m, far_m;
  logic [9:0]  close_e, far_e;
  logic [2:0]  close_grs, far_grs;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
`ifdef FP_ADD_STATUS_EN
  logic        ovf_flag, unf_flag, inx_flag;
`endif

  fp_add_round_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .path_close(path_close), .sign(sign),
    .close_m(close_m), .close_e(close_e), .close_grs(close_grs),
    .far_m(far_m), .far_e(far_e), .far_grs(far_grs),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef FP_ADD_STATUS_EN
    , .ovf_flag(ovf_flag), .unf_flag(unf_flag), .inx_flag(inx_flag)
`endif
  );

  // clock
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_pending = 1'b0;
  logic [W-1:0] held;
  logic         last_accept;
  logic         last_ov;

  function automatic logic [W-1:0] dut_word();
`ifdef FP_ADD_STATUS_EN
    return {result, ovf_flag, unf_flag, inx_flag};
`else
    return {result, 3'b000};
`endif
  endfunction

  // Reference: value-level rounding of the mantissa, then exponent range classification.
  function automatic logic [W-1:0] ref_model(input logic s, input logic [23:0] m,
                                             input logic [9:0] e_raw, input logic [2:0] grs);
    int mant;
    int ex;
    logic ovf, unf, inx;
    logic [31:0] w;
    mant = int'(m);
    ex   = int'($signed(e_raw));
    if (grs[2] && (grs[1] || grs[0] || m[0])) mant = mant + 1;
    if (mant == (1 << 24)) begin
      mant = mant / 2;
      ex   = ex + 1;
    end
    ovf = (ex >= 255);
    unf = !ovf && ((m == 24'h0) || (ex <= 0));
    inx = (grs != 3'b000) || ovf;
    if (ovf)      w = {s, 8'hFF, 23'h0};
    else if (unf) w = {s, 31'h0};
    else          w = {s, ex[7:0], mant[22:0]};
    return {w, ovf, unf, inx};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if ((act & CMP_MASK) !== (req & CMP_MASK)) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act & CMP_MASK, req & CMP_MASK);
    end
  endtask

  // driver + scoreboard: drive at negedge, then account for the handshakes of the next posedge
  task automatic step(input logic iv, input logic pc, input logic s, input logic [23:0] m,
                      input logic [9:0] e, input logic [2:0] grs, input logic ordy);
    @(negedge clk);
    if (stall_pending) check("stall_hold", dut_word(), held);
    in_valid   = iv;
    path_close = pc;
    sign       = s;
    close_m    = pc ? m   : 24'($urandom);
    close_e    = pc ? e   : 10'($urandom);
    close_grs  = pc ? grs : 3'($urandom);
    far_m      = pc ? 24'($urandom) : m;
    far_e      = pc ? 10'($urandom) : e;
    far_grs    = pc ? 3'($urandom)  : grs;
    out_ready  = ordy;
    #1;
    last_accept = in_valid && in_ready;
    last_ov     = out_valid;
    if (last_accept) exp_q.push_back(ref_model(s, m, e, grs));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", {34'h0, 1'b1} << 3, '0);
      else check("result", dut_word(), exp_q.pop_front());
    end
    stall_pending = out_valid && !out_ready;
    held = dut_word();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 24'h0, 10'h0, 3'b000, ordy);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    check("drain_empty", W'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_result", dut_word(), '0);
    exp_q.delete();
    stall_pending = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pin;
    logic [23:0]  rm;
    logic [9:0]   re;
    int           lat;
    int           ei;
    int           sel;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; path_close = 1'b0; sign = 1'b0;
    close_m = '0; close_e = '0; close_grs = '0; far_m = '0; far_e = '0; far_grs = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_result", dut_word(), '0);
    check("reset_in_ready", W'(in_ready), W'(1));

    // hand-computed pins on the reference model
    pin = ref_model(1'b0, 24'hC00000, 10'd127, 3'b000); check("pin_plain", pin, {32'h3FC00000, 3'b000});
    pin = ref_model(1'b0, 24'hFFFFFF, 10'd127, 3'b100); check("pin_carry", pin, {32'h40000000, 3'b001});
    pin = ref_model(1'b0, 24'h800000, 10'd127, 3'b100); check("pin_tie",   pin, {32'h3F800000, 3'b001});
    pin = ref_model(1'b0, 24'hFFFFFF, 10'd254, 3'b110); check("pin_ovf",   pin, {32'h7F800000, 3'b101});
    pin = ref_model(1'b1, 24'h800000, 10'd0,   3'b000); check("pin_unf",   pin, {32'h80000000, 3'b010});

    // directed 1 with latency measurement
    step(1'b1, 1'b1, 1'b0, 24'hC00000, 10'd127, 3'b000, 1'b1);
    lat = 0;
    last_ov = 1'b0;
    while (!last_ov && lat < 10) begin
      idle(1'b1);
      lat++;
    end
    check("latency", W'(lat), W'(2));
    drain();

    // directed 2..4
    step(1'b1, 1'b0, 1'b0, 24'hFFFFFF, 10'd127, 3'b100, 1'b1);
    step(1'b1, 1'b0, 1'b0, 24'h800000, 10'd127, 3'b100, 1'b1);
    step(1'b1, 1'b0, 1'b0, 24'hFFFFFF, 10'd254, 3'b110, 1'b1);
    step(1'b1, 1'b1, 1'b1, 24'h800000, 10'd0,   3'b000, 1'b1);
    step(1'b1, 1'b1, 1'b0, 24'h000000, 10'd100, 3'b000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 24'h900001, 10'h3FE, 3'b011, 1'b1);
    drain();

    // backpressure: two accepted, third held off, then shifted through
    step(1'b1, 1'b0, 1'b0, 24'hA00001, 10'd10, 3'b101, 1'b0);
    check("bp_acc1", W'(last_accept), W'(1));
    step(1'b1, 1'b1, 1'b1, 24'hB00002, 10'd20, 3'b110, 1'b0);
    check("bp_acc2", W'(last_accept), W'(1));
    step(1'b1, 1'b0, 1'b0, 24'hC00003, 10'd30, 3'b111, 1'b0);
    check("bp_in_ready_low", W'(last_accept), '0);
    check("bp_out_valid", W'(last_ov), W'(1));
    step(1'b1, 1'b0, 1'b0, 24'hC00003, 10'd30, 3'b111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 24'hC00003, 10'd30, 3'b111, 1'b1);
    check("bp_shift_through", W'(last_accept), W'(1));
    drain();

    // reset during a stall
    step(1'b1, 1'b1, 1'b0, 24'hD00000, 10'd50, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 24'hE00000, 10'd60, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 24'hF00000, 10'd70, 3'b000, 1'b0);
    do_reset();
    repeat (4) idle(1'b1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rm = 24'hFFFFFF;
      else if (sel == 1) rm = 24'h000000;
      else               rm = {1'b1, 23'($urandom)};
      if (rm == 24'h0) ei = int'($urandom_range(0, 255)) - 5;
      else             ei = int'($urandom_range(0, 270)) - 8;
      re = 10'(ei);
      step(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), rm, re, 3'($urandom),
           ($urandom_range(0, 9) < 7));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
